// File: rtl/core_dispatch_scoreboard_pkg.sv
// Shared micro-architecture types for the dispatch scoreboard.
// Provides register index / mask types, EU selector encoding, latency
// defaults, the LDST tracking record and a one-hot decode helper.
package uarch;

   localparam int unsigned REG_W           = 4;
   localparam int unsigned NUM_REGS        = 16;
   localparam int unsigned ALU_LATENCY_DEF = 1;
   localparam int unsigned MUL_LATENCY_DEF = 3;

   typedef logic [REG_W-1:0]    reg_num;
   typedef logic [NUM_REGS-1:0] hword;

   typedef enum logic [1:0] {
      EU_ALU  = 2'd0,
      EU_MUL  = 2'd1,
      EU_LDST = 2'd2
   } eu_sel;

   // Single outstanding load/store op.
   typedef struct packed {
      logic   pending;
      logic   wb;
      reg_num rd;
   } ldst_ent;

   // One-hot decode of a register index, gated by a valid bit.
   function automatic hword decode(input logic v, input reg_num r);
      return hword'(v) << r;
   endfunction

endpackage

// File: rtl/core_dispatch_scoreboard_if.sv
// Dispatch <-> scoreboard bundle.
// master: dispatch side (drives issue/flush/done, reads masks).
// slave : scoreboard side (reads issue/flush/done, drives masks/busy).
interface core_dispatch_scoreboard_if;
   import uarch::*;

   logic       flush;
   logic       issue_a;
   logic       issue_b;
   logic       wb_a;
   logic       wb_b;
   reg_num     rd_a;
   reg_num     rd_b;
   logic [1:0] eu_a;
   logic [1:0] eu_b;
   logic       ldst_done;

   hword       mask_alu_a;
   hword       mask_alu_b;
   hword       mask_mul;
   hword       mask_ldst;
   hword       mask_busy;
   logic       ldst_busy;

   modport master (
      output flush, issue_a, issue_b, wb_a, wb_b, rd_a, rd_b, eu_a, eu_b, ldst_done,
      input  mask_alu_a, mask_alu_b, mask_mul, mask_ldst, mask_busy, ldst_busy
   );

   modport slave (
      input  flush, issue_a, issue_b, wb_a, wb_b, rd_a, rd_b, eu_a, eu_b, ldst_done,
      output mask_alu_a, mask_alu_b, mask_mul, mask_ldst, mask_busy, ldst_busy
   );

endinterface

// File: rtl/core_dispatch_scoreboard_pipe.sv
// Fixed-depth delay line of {valid, rd} entries with synchronous clear.
// Ports: clk, rst_n (async active-low), clr (sync clear of all entries),
//        in_valid/in_rd (entry shifted in each cycle), mask (OR of decoded
//        valid entries).
module core_dispatch_scoreboard_pipe
   import uarch::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   clr,
   input  logic   in_valid,
   input  reg_num in_rd,
   output hword   mask
);

   logic [DEPTH-1:0] vld;
   reg_num           rd_q [DEPTH];

   // Shift line; an entry lives exactly DEPTH cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int i = 0; i < int'(DEPTH); i++) rd_q[i] <= '0;
      end else if (clr) begin
         vld <= '0;
      end else begin
         vld[0]  <= in_valid;
         rd_q[0] <= in_rd;
         for (int i = 1; i < int'(DEPTH); i++) begin
            vld[i]  <= vld[i-1];
            rd_q[i] <= rd_q[i-1];
         end
      end
   end

   // Mask is rebuilt from live entries every cycle.
   always_comb begin
      mask = '0;
      for (int i = 0; i < int'(DEPTH); i++) mask = mask | decode(vld[i], rd_q[i]);
   end

endmodule

// File: rtl/core_dispatch_scoreboard.sv
// Pending-write scoreboard between dual-issue dispatch and writeback.
// Ports: clk, rst_n (async active-low), sb (slave modport): issue lanes A/B
//        with wb/rd/eu, flush, ldst_done in; per-EU pending masks, combined
//        busy mask and ldst_busy out. Outputs depend only on stored entries.
module core_dispatch_scoreboard
   import uarch::*;
#(
   parameter int unsigned ALU_LATENCY = ALU_LATENCY_DEF,
   parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF
) (
   input logic                     clk,
   input logic                     rst_n,
   core_dispatch_scoreboard_if.slave sb
);

   logic    rec_a, rec_b;
   logic    alu_a_v, alu_b_v;
   logic    mul_a, mul_b, mul_v;
   reg_num  mul_rd;
   logic    ldst_a, ldst_b;
   ldst_ent ldst_q, ldst_d;

   // Issues in a flush cycle are dropped on every unit.
   assign rec_a   = sb.issue_a && !sb.flush;
   assign rec_b   = sb.issue_b && !sb.flush;

   assign alu_a_v = rec_a && sb.wb_a && (sb.eu_a == EU_ALU);
   assign alu_b_v = rec_b && sb.wb_b && (sb.eu_b == EU_ALU);

   // Shared multiplier: lane A wins a (disallowed) double issue.
   assign mul_a   = rec_a && (sb.eu_a == EU_MUL);
   assign mul_b   = rec_b && (sb.eu_b == EU_MUL);
   assign mul_v   = mul_a ? sb.wb_a : (mul_b && sb.wb_b);
   assign mul_rd  = mul_a ? sb.rd_a : sb.rd_b;

   assign ldst_a  = rec_a && (sb.eu_a == EU_LDST);
   assign ldst_b  = rec_b && (sb.eu_b == EU_LDST);

   core_dispatch_scoreboard_pipe #(.DEPTH(ALU_LATENCY)) u_alu_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (sb.flush),
      .in_valid (alu_a_v),
      .in_rd    (sb.rd_a),
      .mask     (sb.mask_alu_a)
   );

   core_dispatch_scoreboard_pipe #(.DEPTH(ALU_LATENCY)) u_alu_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (sb.flush),
      .in_valid (alu_b_v),
      .in_rd    (sb.rd_b),
      .mask     (sb.mask_alu_b)
   );

   core_dispatch_scoreboard_pipe #(.DEPTH(MUL_LATENCY)) u_mul (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (sb.flush),
      .in_valid (mul_v),
      .in_rd    (mul_rd),
      .mask     (sb.mask_mul)
   );

   // LDST record register; survives flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ldst_q <= '0;
      else        ldst_q <= ldst_d;
   end

   // New op is taken when idle or when completing in the same cycle;
   // an issue while busy without done leaves the record untouched.
   always_comb begin
      ldst_d = ldst_q;
      if ((ldst_a || ldst_b) && (!ldst_q.pending || sb.ldst_done)) begin
         ldst_d.pending = 1'b1;
         ldst_d.wb      = ldst_a ? sb.wb_a : sb.wb_b;
         ldst_d.rd      = ldst_a ? sb.rd_a : sb.rd_b;
      end else if (sb.ldst_done) begin
         ldst_d.pending = 1'b0;
      end
   end

   assign sb.mask_ldst = decode(ldst_q.pending && ldst_q.wb, ldst_q.rd);
   assign sb.ldst_busy = ldst_q.pending;
   assign sb.mask_busy = sb.mask_alu_a | sb.mask_alu_b | sb.mask_mul | sb.mask_ldst;

   a_dual_mul: assert property (@(posedge clk) disable iff (!rst_n)
      !(sb.issue_a && sb.issue_b && (sb.eu_a == EU_MUL) && (sb.eu_b == EU_MUL)))
      else $error("two MUL issues in one cycle");

   a_ldst_busy: assert property (@(posedge clk) disable iff (!rst_n)
      !((ldst_a || ldst_b) && ldst_q.pending && !sb.ldst_done))
      else $error("LDST issue while load/store unit busy");

   a_eu_legal: assert property (@(posedge clk) disable iff (!rst_n)
      !((sb.issue_a && (sb.eu_a == 2'd3)) || (sb.issue_b && (sb.eu_b == 2'd3))))
      else $error("illegal EU select");

endmodule

// File: tb/tb_core_dispatch_scoreboard.sv
// Self-checking bench for core_dispatch_scoreboard: directed literal cases
// plus randomized dispatch traffic checked against a per-register
// "pending until cycle" model. A second instance with ALU_LATENCY=2 covers
// the multi-entry WAW case.
module tb_core_dispatch_scoreboard;
   import uarch::*;

   localparam int ALAT = 1;
   localparam int MLAT = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush, issue_a, issue_b, wb_a, wb_b, ldst_done;
   logic [3:0] rd_a, rd_b;
   logic [1:0] eu_a, eu_b;

   int n_vec  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   core_dispatch_scoreboard_if sb1 ();
   core_dispatch_scoreboard_if sb2 ();

   assign sb1.flush = flush;     assign sb2.flush = flush;
   assign sb1.issue_a = issue_a; assign sb2.issue_a = issue_a;
   assign sb1.issue_b = issue_b; assign sb2.issue_b = issue_b;
   assign sb1.wb_a = wb_a;       assign sb2.wb_a = wb_a;
   assign sb1.wb_b = wb_b;       assign sb2.wb_b = wb_b;
   assign sb1.rd_a = rd_a;       assign sb2.rd_a = rd_a;
   assign sb1.rd_b = rd_b;       assign sb2.rd_b = rd_b;
   assign sb1.eu_a = eu_a;       assign sb2.eu_a = eu_a;
   assign sb1.eu_b = eu_b;       assign sb2.eu_b = eu_b;
   assign sb1.ldst_done = ldst_done;
   assign sb2.ldst_done = ldst_done;

   core_dispatch_scoreboard #(.ALU_LATENCY(ALAT), .MUL_LATENCY(MLAT)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (sb1)
   );

   core_dispatch_scoreboard #(.ALU_LATENCY(2), .MUL_LATENCY(MLAT)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (sb2)
   );

   always #5 clk = ~clk;

   // Model: for each register, the last edge count at which it is still pending.
   int         now;
   int         ua [16];
   int         ub [16];
   int         um [16];
   logic       lp, lw;
   logic [3:0] lr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         now <= 0;
         for (int r = 0; r < 16; r++) begin
            ua[r] <= -1; ub[r] <= -1; um[r] <= -1;
         end
         lp <= 1'b0; lw <= 1'b0; lr <= 4'd0;
      end else begin
         now <= now + 1;
         if (flush) begin
            for (int r = 0; r < 16; r++) begin
               ua[r] <= -1; ub[r] <= -1; um[r] <= -1;
            end
         end else begin
            if (issue_a && wb_a && eu_a == 2'd0 && now + ALAT > ua[rd_a]) ua[rd_a] <= now + ALAT;
            if (issue_b && wb_b && eu_b == 2'd0 && now + ALAT > ub[rd_b]) ub[rd_b] <= now + ALAT;
            if (issue_a && eu_a == 2'd1) begin
               if (wb_a && now + MLAT > um[rd_a]) um[rd_a] <= now + MLAT;
            end else if (issue_b && eu_b == 2'd1) begin
               if (wb_b && now + MLAT > um[rd_b]) um[rd_b] <= now + MLAT;
            end
         end
         if (!flush && ((issue_a && eu_a == 2'd2) || (issue_b && eu_b == 2'd2))
             && (!lp || ldst_done)) begin
            lp <= 1'b1;
            lw <= (issue_a && eu_a == 2'd2) ? wb_a : wb_b;
            lr <= (issue_a && eu_a == 2'd2) ? rd_a : rd_b;
         end else if (ldst_done) begin
            lp <= 1'b0;
         end
      end
   end

   function automatic logic [15:0] live(input int a [16]);
      logic [15:0] m = '0;
      for (int r = 0; r < 16; r++) m[r] = (a[r] >= now);
      return m;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of the default instance against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [15:0] ea, eb, em, el;
         ea = live(ua);
         eb = live(ub);
         em = live(um);
         el = (lp && lw) ? (16'd1 << lr) : 16'd0;
         check("mask_alu_a", sb1.mask_alu_a, ea);
         check("mask_alu_b", sb1.mask_alu_b, eb);
         check("mask_mul",   sb1.mask_mul,   em);
         check("mask_ldst",  sb1.mask_ldst,  el);
         check("mask_busy",  sb1.mask_busy,  ea | eb | em | el);
         check("ldst_busy",  16'(sb1.ldst_busy), 16'(lp));
      end
   end

   task automatic idle();
      flush = 0; issue_a = 0; issue_b = 0; wb_a = 0; wb_b = 0;
      rd_a = 0; rd_b = 0; eu_a = 0; eu_b = 0; ldst_done = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic lane_a(input logic [1:0] eu, input logic [3:0] rd, input logic wb);
      issue_a = 1; eu_a = eu; rd_a = rd; wb_a = wb;
   endtask

   task automatic lane_b(input logic [1:0] eu, input logic [3:0] rd, input logic wb);
      issue_b = 1; eu_b = eu; rd_b = rd; wb_b = wb;
   endtask

   // Random legal dispatch for one cycle, using the model's LDST state.
   task automatic rand_drive();
      logic ok;
      idle();
      flush     = ($urandom_range(0, 15) == 0);
      ldst_done = ($urandom_range(0, 3) == 0);
      issue_a   = ($urandom_range(0, 99) < 70);
      issue_b   = issue_a && ($urandom_range(0, 99) < 50);
      wb_a      = ($urandom_range(0, 3) != 0);
      wb_b      = ($urandom_range(0, 3) != 0);
      rd_a      = 4'($urandom_range(0, 15));
      rd_b      = ($urandom_range(0, 3) == 0) ? rd_a : 4'($urandom_range(0, 15));
      eu_a      = 2'($urandom_range(0, 2));
      eu_b      = 2'($urandom_range(0, 2));
      ok = !lp || ldst_done;
      if (eu_a == 2'd2 && !ok) eu_a = 2'd0;
      if (eu_b == 2'd2 && (!ok || (issue_a && eu_a == 2'd2))) eu_b = 2'd0;
      if (issue_b && eu_a == 2'd1 && eu_b == 2'd1) eu_b = 2'd0;
   endtask

   initial begin
      idle();
      rst_n = 0;
      repeat (2) @(negedge clk);
      rst_n  = 1;
      chk_en = 1;

      // Reset state.
      check("rst_busy", sb1.mask_busy, 16'h0000);
      check("rst_ldst_busy", 16'(sb1.ldst_busy), 16'h0000);

      // ALU lane A rd=5, latency 1.
      lane_a(2'd0, 4'd5, 1);
      tick(); idle();
      check("alu_c1", sb1.mask_alu_a, 16'h0020);
      tick();
      check("alu_c2", sb1.mask_alu_a, 16'h0000);

      // MUL rd=3 then rd=4 back to back.
      lane_a(2'd1, 4'd3, 1);
      tick();
      check("mul_c1", sb1.mask_mul, 16'h0008);
      idle(); lane_a(2'd1, 4'd4, 1);
      tick(); idle();
      check("mul_c2", sb1.mask_mul, 16'h0018);
      tick(); check("mul_c3", sb1.mask_mul, 16'h0018);
      tick(); check("mul_c4", sb1.mask_mul, 16'h0010);
      tick(); check("mul_c5", sb1.mask_mul, 16'h0000);

      // LDST rd=7, done + new rd=2 at cycle 4.
      lane_a(2'd2, 4'd7, 1);
      tick(); idle();
      for (int c = 1; c <= 4; c++) begin
         check("ldst_hold", sb1.mask_ldst, 16'h0080);
         check("ldst_hold_busy", 16'(sb1.ldst_busy), 16'h0001);
         if (c < 4) tick();
      end
      lane_a(2'd2, 4'd2, 1); ldst_done = 1;
      tick(); idle();
      check("ldst_next", sb1.mask_ldst, 16'h0004);
      check("ldst_next_busy", 16'(sb1.ldst_busy), 16'h0001);
      ldst_done = 1;
      tick(); idle();
      check("ldst_clear", sb1.mask_ldst, 16'h0000);
      check("ldst_clear_busy", 16'(sb1.ldst_busy), 16'h0000);

      // Flush keeps only the LDST entry.
      lane_a(2'd1, 4'd9, 1); lane_b(2'd2, 4'd12, 1);
      tick(); idle();
      lane_a(2'd0, 4'd1, 1);
      tick(); idle();
      check("pre_flush", sb1.mask_busy, 16'h1202);
      flush = 1; lane_a(2'd0, 4'd0, 0); lane_b(2'd0, 4'd6, 1);
      tick(); idle();
      check("post_flush", sb1.mask_busy, 16'h1000);
      ldst_done = 1;
      tick(); idle();

      // WAW on the ALU_LATENCY=2 instance.
      lane_a(2'd0, 4'd10, 1); lane_b(2'd0, 4'd10, 1);
      tick(); idle();
      check("waw_c1", 16'(sb2.mask_busy[10]), 16'h0001);
      check("waw_c1_b", sb2.mask_alu_b, 16'h0400);
      lane_a(2'd0, 4'd10, 1);
      tick(); idle();
      check("waw_c2", 16'(sb2.mask_busy[10]), 16'h0001);
      tick();
      check("waw_c3", 16'(sb2.mask_busy[10]), 16'h0001);
      check("waw_c3_b", sb2.mask_alu_b, 16'h0000);
      tick();
      check("waw_c4", 16'(sb2.mask_busy[10]), 16'h0000);

      // Asynchronous reset with MUL and LDST pending.
      lane_a(2'd1, 4'd3, 1); lane_b(2'd2, 4'd8, 1);
      tick(); idle();
      check("pre_rst_mul", sb1.mask_mul, 16'h0008);
      check("pre_rst_ldst_busy", 16'(sb1.ldst_busy), 16'h0001);
      #2 rst_n = 0;
      #1;
      check("rst_mul", sb1.mask_mul, 16'h0000);
      check("rst_busy_mask", sb1.mask_busy, 16'h0000);
      check("rst_ldst_busy_async", 16'(sb1.ldst_busy), 16'h0000);
      @(negedge clk);
      rst_n = 1;
      tick();
      check("rel_busy_mask", sb1.mask_busy, 16'h0000);
      check("rel_ldst_busy", 16'(sb1.ldst_busy), 16'h0000);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rand_drive();
         tick();
      end
      idle();
      tick();
      chk_en = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/core_dispatch_scoreboard.md
# core_dispatch_scoreboard

Tracks every register write in flight between dispatch and writeback and publishes per-execution-unit pending-write masks to the dispatch hazard check. It sits beside the dispatch stage. It is updated by the dual-issue dispatch fires (lanes A and B) and by EU completions. It also reports structural busy for the multi-cycle units: the multiplier and the load/store unit.

## Interface
- `ALU_LATENCY`, default 1: cycles an ALU write stays pending after issue (≥1).
- `MUL_LATENCY`, default 3: multiplier pipeline depth in cycles (≥1). The multiplier is fully pipelined.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `flush`  in  1  discard speculative pending writes: ALU and MUL entries.
- `issue_a`, `issue_b`  in  1  lane A / lane B dispatched this cycle. `issue_b` implies `issue_a`.
- `wb_a`, `wb_b`  in  1  the dispatched instruction writes `rd`.
- `rd_a`, `rd_b`  in  4  destination register index.
- `eu_a`, `eu_b`  in  2  target EU: 0 = ALU, 1 = MUL, 2 = LDST. 3 is illegal.
- `ldst_done`  in  1  the load/store unit completes its single outstanding op this cycle.
- `mask_alu_a`, `mask_alu_b`  out  16  one-hot-or pending ALU writes per lane.
- `mask_mul`  out  16  pending multiplier writes.
- `mask_ldst`  out  16  pending load write.
- `mask_busy`  out  16  OR of all four masks.
- `ldst_busy`  out  1  a load/store op is outstanding.

## Operation
- **Issue rule:** an instruction is recorded only when its lane's issue bit is high and its `wb_*` bit is high. An issue without writeback still occupies the EU slot for LDST busy; it marks no register.
- **ALU lanes:** each lane has a delay line of `ALU_LATENCY` entries. Each entry holds a valid bit and `rd`. `mask_alu_x` is the OR of the decoded valid entries.
- **MUL:** a single shift pipeline of `MUL_LATENCY` entries, shared by both lanes. Dispatch never issues two MULs in one cycle. If both lanes target MUL in the same cycle, lane A is recorded and a simulation assertion fires.
- **LDST:** a single register made of `{pending, wb, rd}`.
  - LDST issue when `ldst_busy` is high is illegal (assertion); the state is unchanged.
  - `ldst_done` clears the register. Asserting `ldst_done` with no op pending is ignored.
  - Done and a new issue in the same cycle: the new op is captured and busy stays high.
- **flush:** clears all ALU and MUL entries in the same edge. Any issue in the flush cycle is also dropped. LDST state is kept, because a memory op in flight must complete.
- **WAW:** both lanes may name the same `rd`, and each lane tracks its own copy. A bit clears only when no entry anywhere still holds that register.
- **No merging:** masks are recomputed each cycle from the entries, never held as sticky bits.
- **Reset:** all entries are invalid. Every mask output is 0 and `ldst_busy` is 0. Reset during operation drops everything immediately, asynchronously.

## Timing
- Entries are registered on `clk`, and all outputs are combinational from those entries. There is no path from issue inputs to outputs in the same cycle.
- **ALU:** issue at edge N makes the bit visible in cycles N+1 .. N+`ALU_LATENCY`. It is clear at N+`ALU_LATENCY`+1.
- **MUL:** issue at edge N makes the bit visible in cycles N+1 .. N+`MUL_LATENCY`.
- **LDST:** issue at edge N makes the bit and `ldst_busy` high from N+1. They fall in the cycle after the edge where `ldst_done` is sampled high.
- **Back-to-back:** MUL issues may come every cycle. The pipeline never stalls, so throughput is 1 per cycle.

## Structure
- Shared `uarch` package:
  - `reg_num` (4 bits) and `hword` (16-bit mask).
  - enum `eu_sel` with `EU_ALU`, `EU_MUL`, `EU_LDST`.
  - defaults for `ALU_LATENCY` and `MUL_LATENCY`.
- One sub-module, `core_dispatch_scoreboard_pipe`:
  - parameterised depth; inputs valid+rd; output decoded mask.
  - has a synchronous clear.
  - instantiated three times: ALU A, ALU B and MUL.

## Test plan
- **Reset:** `rst_n`=0 mid-run with MUL entries valid → all masks = 0 and `ldst_busy` = 0 immediately. They stay 0 on release.
- **ALU:** issue A, ALU, `rd`=5 at cycle 0, defaults → `mask_alu_a` = 0x0020 in cycle 1 only, 0 in cycle 2.
- **MUL:** MUL `rd`=3 at cycle 0, then MUL `rd`=4 at cycle 1 → `mask_mul` reads 0x0008, 0x0018, 0x0018, 0x0010, 0 over cycles 1..5.
- **LDST:** LDST `rd`=7 at cycle 0, `ldst_done` at cycle 4 with a new LDST `rd`=2 in the same cycle → `mask_ldst` = 0x0080 for cycles 1..4, then 0x0004, with `ldst_busy` continuously 1.
- **Flush:** ALU `rd`=1, MUL `rd`=9 and LDST `rd`=12 are pending; flush, plus a lane-B ALU issue of `rd`=6 in the same cycle → next cycle `mask_busy` = 0x1000.
- **WAW:** lanes A and B both ALU `rd`=10 with `ALU_LATENCY`=2, then lane A ALU `rd`=10 again next cycle → bit 10 of `mask_busy` is stays set through cycle 3 and clears in cycle 4.
